vscpu_core: RTL

Parametrised multi-cycle core for the 16-opcode memory-to-memory ISA. Every operand lives in a single unified RAM. Address and data widths are set by parameters, and all RAM traffic goes through a req/ack handshake, so wait-state memories work. It adds halt detection and a retired-instruction counter, and sits between the top-level RAM model/arbiter and the testbench or debug logic.

---
 rtl/vscpu_core.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vscpu_core.sv
// vscpu_core: multi-cycle memory-to-memory CPU core with req/ack RAM port, halt detection and retired-instruction counter
// Ports: clk, rst (synchronous, active-high)
//        mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ack in; an access completes on a clk edge with mem_req & mem_ack
//        pc (current PC), halted (core stopped), instret (retired instruction count)
module vscpu_core #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  instret
);
    localparam int N  = ADDR_W;
    localparam int IW = 2 * N + 4;
    localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);
    localparam logic [2:0] S_FETCH = 3'd0, S_RD_A = 3'd1, S_RD_B = 3'd2, S_RD_I = 3'd3, S_WR = 3'd4, S_HALT = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              req_q, req_d, we_q, we_d, halted_q, halted_d, retire;
    logic [N-1:0]      addr_q, addr_d, pc_q, pc_d, npc;
    logic [DATA_W-1:0] wdata_q, wdata_d, r1_q, r1_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic [IW-1:0]     ins_q, ins_d;

    logic [3:0]        op, op_f;
    logic [N-1:0]      a, b, a_f, b_f;
    logic [DATA_W-1:0] bz, bz_f;

    // *_f fields decode the word arriving during FETCH; the others decode the latched instruction
    assign op_f = mem_rdata[2*N+3:2*N];
    assign a_f  = mem_rdata[2*N-1:N];
    assign b_f  = mem_rdata[N-1:0];
    assign bz_f = DATA_W'(b_f);
    assign op   = ins_q[2*N+3:2*N];
    assign a    = ins_q[2*N-1:N];
    assign b    = ins_q[N-1:0];
    assign bz   = DATA_W'(b);

    // op[3:1] selects the ALU function for ops 0-7 and 14-15; shifts past DATA_W fall out as 0
    function automatic logic [DATA_W-1:0] alu(input logic [3:0] o, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
        return o[3:1] == 3'd0 ? x + y :
               o[3:1] == 3'd1 ? ~(x & y) :
               o[3:1] == 3'd2 ? (y < DW ? x >> y : x << (y - DW)) :
               o[3:1] == 3'd3 ? DATA_W'(x < y) :
               x * y;
    endfunction

    // The next access is set up on the same edge that acks the current one, so zero-wait memories stream back-to-back
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pc_d      = pc_q;
        halted_d  = halted_q;
        instret_d = instret_q;
        ins_d     = ins_q;
        r1_d      = r1_q;
        retire    = 1'b0;
        npc       = pc_q + 1'b1;
        if (!req_q) begin
            if (state_q == S_FETCH) begin
                req_d  = 1'b1;
                we_d   = 1'b0;
                addr_d = pc_q;
            end
        end else if (mem_ack) begin
            case (state_q)
                S_FETCH: begin
                    ins_d = mem_rdata[IW-1:0];
                    if (op_f == 4'd9) begin
                        state_d = S_WR;
                        we_d    = 1'b1;
                        addr_d  = a_f;
                        wdata_d = bz_f;
                    end else begin
                        state_d = (op_f == 4'd8 || op_f == 4'd10) ? S_RD_B : S_RD_A;
                        addr_d  = (op_f == 4'd8 || op_f == 4'd10) ? b_f : a_f;
                    end
                end
                S_RD_A: begin
                    r1_d = mem_rdata;
                    if (op == 4'd13) begin
                        retire = 1'b1;
                        npc    = mem_rdata[N-1:0] + b;
                    end else if (op[0] && op != 4'd11) begin
                        state_d = S_WR;
                        we_d    = 1'b1;
                        addr_d  = a;
                        wdata_d = alu(op, mem_rdata, bz);
                    end else begin
                        state_d = S_RD_B;
                        addr_d  = b;
                    end
                end
                S_RD_B: begin
                    if (op == 4'd10) begin
                        state_d = S_RD_I;
                        addr_d  = mem_rdata[N-1:0];
                    end else if (op == 4'd12) begin
                        retire = 1'b1;
                        npc    = mem_rdata == '0 ? r1_q[N-1:0] : pc_q + 1'b1;
                    end else begin
                        state_d = S_WR;
                        we_d    = 1'b1;
                        addr_d  = op == 4'd11 ? r1_q[N-1:0] : a;
                        wdata_d = (op == 4'd8 || op == 4'd11) ? mem_rdata : alu(op, r1_q, mem_rdata);
                    end
                end
                S_RD_I: begin
                    state_d = S_WR;
                    we_d    = 1'b1;
                    addr_d  = a;
                    wdata_d = mem_rdata;
                end
                default: retire = 1'b1;
            endcase
            // Only a branch can produce npc == pc, so this is the halt test
            if (retire) begin
                pc_d      = npc;
                instret_d = instret_q + 1'b1;
                we_d      = 1'b0;
                addr_d    = npc;
                state_d   = npc == pc_q ? S_HALT : S_FETCH;
                req_d     = npc != pc_q;
                halted_d  = npc == pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            halted_q  <= 1'b0;
            instret_q <= '0;
            ins_q     <= '0;
            r1_q      <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pc_q      <= pc_d;
            halted_q  <= halted_d;
            instret_q <= instret_d;
            ins_q     <= ins_d;
            r1_q      <= r1_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign instret   = instret_q;
endmodule
